// File: rtl/serial_mult_4bit_seq.sv
// Sequential shift-and-add unsigned multiplier.
// It handles one multiplier bit per clock, so a product takes WIDTH RUN edges.
// Operands arrive over a valid/ready handshake and the product leaves over a
// second valid/ready handshake. Only one operation is in flight at a time.
module serial_mult_4bit_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0] acc_step;

  // One shift-add step. The upper half of acc plus the gated multiplicand is
  // W+1 bits wide, so the carry shifts into the top bit and is never lost.
  always_comb begin
    addend   = mplier_q[0] ? mcand_q : '0;
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_step = {sum, acc_q[WIDTH-1:1]};
  end

  // Next-state and datapath control for IDLE -> RUN -> DONE.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    p_d         = p_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Hold cnt on the last step so it never wraps.
          p_d         = acc_step;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers. Reset aborts any run and discards the partial product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Status outputs are decoded from the state register, so they follow
  // reset immediately without waiting for a clock edge.
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign p         = p_q;

endmodule

// File: tb/tb_serial_mult_4bit_seq.sv
// Bench for serial_mult_4bit_seq. A WIDTH=4 instance is driven with directed
// and random operations, and its products are checked through a scoreboard
// queue. A WIDTH=8 instance receives a few directed operations.
module tb_serial_mult_4bit_seq;
  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] a, b;
  logic [7:0] p;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int checks = 0;
  int errors = 0;
  int unsigned exp_q[$];

  always #5 clk = ~clk;

  serial_mult_4bit_seq #(.WIDTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p),
    .busy(busy)
  );

  serial_mult_4bit_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .p(p8),
    .busy(busy8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // The monitor samples on the falling edge. When valid and ready are both
  // high there, the next rising edge completes a handshake, so the expected
  // product is popped from the queue and compared.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_output", 32'(p), 32'hFFFF_FFFF);
      end else begin
        chk("sb_product", 32'(p), exp_q.pop_front());
      end
    end
  end

  // Perform one operation on the 4-bit DUT. Ignored inputs are scrambled
  // during RUN and DONE. The output is stalled for 'stall' cycles and then
  // released.
  task automatic run_op(input int ta, input int tb_v, input int stall);
    int n;
    int unsigned prod;
    prod = 32'(ta) * 32'(tb_v);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    a = 4'(ta); b = 4'(tb_v); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(prod);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("in_ready_run", 32'(in_ready), 32'd0);
    for (int k = 1; k <= W; k++) begin
      a = 4'($urandom); b = 4'($urandom);
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      @(posedge clk); #1;
      chk("latency_out_valid", 32'(out_valid), (k == W) ? 32'd1 : 32'd0);
    end
    out_ready = 1'b0; in_valid = 1'b0;
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_p", 32'(p), prod);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      a = 4'($urandom); b = 4'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("done_p", 32'(p), prod);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_busy", 32'(busy), 32'd0);
    chk("p_held", 32'(p), prod);
  endtask

  // Perform one operation on the 8-bit DUT and check the latency directly.
  task automatic run_op8(input int ta, input int tb_v);
    int unsigned prod;
    prod = 32'(ta) * 32'(tb_v);
    a8 = 8'(ta); b8 = 8'(tb_v); in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      a8 = 8'($urandom);
      @(posedge clk); #1;
      chk("w8_latency", 32'(out_valid8), (k == 8) ? 32'd1 : 32'd0);
    end
    chk("w8_product", 32'(p8), prod);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk("w8_release", 32'(in_ready8), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_p", 32'(p), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases.
    run_op(15, 15, 0);
    run_op(0, 9, 0);
    run_op(1, 1, 0);
    run_op(9, 0, 0);
    run_op(8, 2, 0);
    run_op(7, 6, 5);

    // Abort: reset asserted mid-RUN, between clock edges.
    a = 4'd13; b = 4'd11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_p", 32'(p), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_output", 32'(out_valid), 32'd0);
    run_op(3, 5, 0);

    // Exhaustive sweep of every operand pair, back-to-back.
    for (int i = 0; i < 256; i++) run_op(i / 16, i % 16, 0);

    // Random operands with random backpressure.
    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)));

    // Wider instance.
    run_op8(255, 255);
    run_op8(0, 200);
    for (int i = 0; i < 6; i++)
      run_op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
